mem_access_unit: RTL
====================

# mem_access_unit

Memory stage of the RV32I pipeline, on the receiving side of the ALU→MEM pipeline register. It takes each registered ALU result with its control bits and performs the data-RAM access over a req/ready handshake, stalling upstream while a request is outstanding. It formats load data by byte lane with sign or zero extension and hands the write-back payload to MEM_WB. Non-memory operations pass through with one cycle of latency.

## Interface
- DATA_W, 32, data and address width
- REG_ADDR_W, 5, register-file address width
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- validIn  in  1  upstream slot holds a live instruction
- addrIn  in  DATA_W  ALU result: effective address for memory ops, result value otherwise
- storeDataIn  in  DATA_W  rs2 value for stores
- memReadIn / memWriteIn  in  1 each  load / store request
- funct3In  in  3  access size and sign (RV32I encoding)
- writeEnableIn  in  1  instruction writes rd
- writeBackAddrIn  in  REG_ADDR_W  rd index
- stallOut  out  1  hold upstream register contents
- memReq  out  1  RAM request valid
- memWe  out  1  1 = store
- memAddr  out  DATA_W  word-aligned address ({addr[31:2],2'b00})
- memWdata  out  DATA_W  lane-replicated store data
- memBe  out  4  byte enables
- memReady  in  1  RAM completes request (load data valid the same cycle)
- memRdata  in  DATA_W  RAM read word
- writeEnableOut  out  1  to MEM_WB
- writeBackAddrOut  out  REG_ADDR_W  to MEM_WB
- dataOut  out  DATA_W  write-back value
- memFaultOut  out  1  one-cycle pulse: misaligned or illegal access

## Operation
- States: IDLE, WAIT.
- IDLE, validIn=0: all MEM_WB outputs load 0 (bubble).
- IDLE, validIn=1, no memory op: dataOut←addrIn, writeEnableOut←writeEnableIn, writeBackAddrOut←writeBackAddrIn.
- IDLE, memory op, legal and aligned: latch memAddr, memWe, memBe, memWdata and the rd, funct3 and load flag. Set memReq←1, go to WAIT. Emit a bubble to MEM_WB.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000, 001, 010. Any other funct3, memReadIn and memWriteIn both set, halfword with addr[0]=1, or word with addr[1:0]≠0 is a fault: memFaultOut←1 for one cycle, no request, writeEnableOut←0.
- Stores, little-endian:
  - SB: memBe=1<<addr[1:0], memWdata={4{byte}}.
  - SH: memBe=0011 if addr[1]=0, else 1100; memWdata={2{half}}.
  - SW: memBe=1111.
  - Loads drive memBe=1111.
- WAIT: request fields are held stable until memReady=1. On that edge:
  - memReq←0, state←IDLE.
  - Load: dataOut←lane of memRdata selected by the latched addr[1:0], sign/zero-extended per funct3; writeEnableOut←latched writeEnable.
  - Store: writeEnableOut←0.
- memReady while IDLE is ignored.
- stallOut = (state==WAIT), decoded from registered state only.

## Timing
- Reset values: state IDLE; all outputs 0, including memReq, memAddr, memBe, dataOut, stallOut, memFaultOut.
- Non-memory op: result appears at MEM_WB outputs one edge after presentation.
- Memory op accepted at edge E0: memReq is high from E0 to the edge where memReady is sampled high (E1 ≥ E0+1). The result is registered at E1. Minimum two cycles per access.
- Stall window: upstream advances once at E0 (the next instruction is presented), then holds it through WAIT. That instruction is accepted at the edge after E1.
- Reset during WAIT: at the next edge memReq←0, state←IDLE, and the result is discarded. The RAM must tolerate an abandoned request.

## Structure
- Shared define file/package: DataSize and RegAddrSize widths, funct3 load/store encodings, state encoding.
- One natural sub-module: load_align (combinational lane select plus extension from memRdata, addr[1:0], funct3). Store lane replication and byte enables stay inline.

## Test plan
- ALU pass-through: validIn=1, addrIn=0x00001234, writeEnableIn=1, rd=5 → next edge dataOut=0x00001234, writeEnableOut=1, writeBackAddrOut=5; memReq stays 0.
- LB at 0x00000103, memRdata=0x80FF0000, memReady after 3 WAIT cycles → stallOut high 3 cycles, dataOut=0xFFFFFF80. Same access as LBU → dataOut=0x00000080.
- SH at 0x00000202, storeData=0xABCD1234 → memAddr=0x00000200, memBe=1100, memWdata=0x12341234, memWe=1, writeEnableOut=0 on completion.
- LW at 0x00000101 → memFaultOut pulses 1 cycle, no memReq, writeEnableOut=0, no stall.
- Reset asserted mid-WAIT → next edge memReq=0, stallOut=0, all outputs 0. A following LW completes normally.
- LW at 0x10 (memRdata=0xDEADBEEF, rd=3) followed by ALU op (0x55, rd=4) → load result registered at E1; ALU result registered one edge after E1; no instruction lost or duplicated.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared widths, RV32I load/store funct3 encodings, the state
//            encoding of the memory stage and the access legality helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam int DATA_SIZE     = 32;
    localparam int REG_ADDR_SIZE = 5;

    // funct3 encodings for loads; stores reuse the first three.
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // A memory access is legal when exactly one of load/store is requested,
    // funct3 names a size valid for that direction, and the address is
    // naturally aligned for that size.
    function automatic logic access_legal(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic ok;
        case (funct3)
            c_F3_B:  ok = 1'b1;
            c_F3_H:  ok = ~offset[0];
            c_F3_W:  ok = (offset == 2'b00);
            c_F3_BU: ok = is_load;
            c_F3_HU: ok = is_load & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok & ~(is_load & is_store);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// ============================================================================
// Module   : mem_access_unit_load_align
// Purpose  : Selects the addressed byte/halfword lane of a RAM read word and
//            sign- or zero-extends it according to the load funct3.
// Ports    : i_rdata  - RAM read word
//            i_offset - byte offset within the word (addr[1:0])
//            i_funct3 - load size/sign encoding
//            o_data   - extended write-back value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_SIZE-1:0] i_rdata,
    input  logic [1:0]           i_offset,
    input  logic [2:0]           i_funct3,
    output logic [DATA_SIZE-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfwords are aligned by the time they get here, so only bit 1 matters.
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            c_F3_B:  o_data = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  o_data = {{16{w_half[15]}}, w_half};
            c_F3_BU: o_data = {24'd0, w_byte};
            c_F3_HU: o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : RV32I memory stage. Issues data-RAM requests over a req/ready
//            handshake, stalls upstream while a request is outstanding,
//            formats load data and drives the MEM_WB payload. Non-memory
//            instructions pass through with one cycle of latency.
// Ports    : clk/reset            - clock, synchronous active-high reset
//            validIn..writeBackAddrIn - ALU->MEM pipeline register contents
//            stallOut             - hold upstream while waiting on the RAM
//            memReq..memBe        - RAM request (held stable in WAIT)
//            memReady/memRdata    - RAM completion and read word
//            writeEnableOut, writeBackAddrOut, dataOut - to MEM_WB
//            memFaultOut          - one-cycle pulse on misaligned/illegal access
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W     = DATA_SIZE,
    parameter int REG_ADDR_W = REG_ADDR_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  validIn,
    input  logic [DATA_W-1:0]     addrIn,
    input  logic [DATA_W-1:0]     storeDataIn,
    input  logic                  memReadIn,
    input  logic                  memWriteIn,
    input  logic [2:0]            funct3In,
    input  logic                  writeEnableIn,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    output logic                  stallOut,
    output logic                  memReq,
    output logic                  memWe,
    output logic [DATA_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWdata,
    output logic [3:0]            memBe,
    input  logic                  memReady,
    input  logic [DATA_W-1:0]     memRdata,
    output logic                  writeEnableOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut,
    output logic [DATA_W-1:0]     dataOut,
    output logic                  memFaultOut
);

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  r_lat_load;
    logic                  r_lat_we;
    logic [REG_ADDR_W-1:0] r_lat_rd;
    logic [2:0]            r_lat_funct3;
    logic [1:0]            r_lat_offset;
    logic                  r_we_out;
    logic [REG_ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]     r_data;
    logic                  r_fault;

    logic                  w_is_mem;
    logic                  w_legal;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_load_data;

    assign w_is_mem = memReadIn | memWriteIn;
    assign w_legal  = access_legal(memReadIn, memWriteIn, funct3In, addrIn[1:0]);

    // Store lanes: data is replicated across the word so the RAM only needs
    // the byte enables to pick the right lane. Loads read the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = storeDataIn;
        if (memWriteIn) begin
            case (funct3In[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addrIn[1:0];
                    w_wdata = {4{storeDataIn[7:0]}};
                end
                2'b01: begin
                    w_be    = addrIn[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{storeDataIn[15:0]}};
                end
                default: ;
            endcase
        end
    end

    mem_access_unit_load_align u_load_align (
        .i_rdata  (memRdata),
        .i_offset (r_lat_offset),
        .i_funct3 (r_lat_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= 4'b0000;
            r_lat_load   <= 1'b0;
            r_lat_we     <= 1'b0;
            r_lat_rd     <= '0;
            r_lat_funct3 <= 3'b000;
            r_lat_offset <= 2'b00;
            r_we_out     <= 1'b0;
            r_wb_addr    <= '0;
            r_data       <= '0;
            r_fault      <= 1'b0;
        end else begin
            // Default MEM_WB payload is a bubble; branches below override it.
            r_fault   <= 1'b0;
            r_we_out  <= 1'b0;
            r_wb_addr <= '0;
            r_data    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (validIn) begin
                        if (!w_is_mem) begin
                            r_data    <= addrIn;
                            r_we_out  <= writeEnableIn;
                            r_wb_addr <= writeBackAddrIn;
                        end else if (!w_legal) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_mem_req    <= 1'b1;
                            r_mem_we     <= memWriteIn;
                            r_mem_addr   <= {addrIn[DATA_W-1:2], 2'b00};
                            r_mem_wdata  <= w_wdata;
                            r_mem_be     <= w_be;
                            r_lat_load   <= memReadIn;
                            r_lat_we     <= writeEnableIn;
                            r_lat_rd     <= writeBackAddrIn;
                            r_lat_funct3 <= funct3In;
                            r_lat_offset <= addrIn[1:0];
                            r_state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (memReady) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (r_lat_load) begin
                            r_data    <= w_load_data;
                            r_we_out  <= r_lat_we;
                            r_wb_addr <= r_lat_rd;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stallOut         = (r_state == ST_WAIT);
    assign memReq           = r_mem_req;
    assign memWe            = r_mem_we;
    assign memAddr          = r_mem_addr;
    assign memWdata         = r_mem_wdata;
    assign memBe            = r_mem_be;
    assign writeEnableOut   = r_we_out;
    assign writeBackAddrOut = r_wb_addr;
    assign dataOut          = r_data;
    assign memFaultOut      = r_fault;

endmodule

`default_nettype wire
